// File: rtl/prog_sequencer_if.sv
// Bench-facing bus of prog_sequencer: Start/Ack handshake, instruction feed,
// entry-table config port and the PC/core control outputs.
interface prog_sequencer_if #(
  parameter int PC_W   = 10,
  parameter int INST_W = 9
);
  logic              Start;
  logic [INST_W-1:0] Instruction;
  logic              CfgWe;
  logic [1:0]        CfgIdx;
  logic [PC_W-1:0]   CfgAddr;
  logic              PcLoad;
  logic [PC_W-1:0]   PcLoadAddr;
  logic              CoreEn;
  logic              Ack;
  logic [1:0]        ProgIdx;
  logic [15:0]       CycleCt;
  logic              Timeout;

  modport master (
    output Start, Instruction, CfgWe, CfgIdx, CfgAddr,
    input  PcLoad, PcLoadAddr, CoreEn, Ack, ProgIdx, CycleCt, Timeout
  );
  modport slave (
    input  Start, Instruction, CfgWe, CfgIdx, CfgAddr,
    output PcLoad, PcLoadAddr, CoreEn, Ack, ProgIdx, CycleCt, Timeout
  );
endinterface

// File: rtl/prog_sequencer.sv
// Run controller: loads the PC from a small entry table, gates the core until
// halt or watchdog expiry, counts RUN cycles and drives the Start/Ack handshake.
module prog_sequencer #(
  parameter int                NUM_PROGS = 3,
  parameter int                PC_W      = 10,
  parameter int                INST_W    = 9,
  parameter logic [INST_W-1:0] HALT_OP   = 9'h1FF,
  parameter logic [15:0]       TIMEOUT   = 16'd4000
) (
  input logic             Clk,
  input logic             Reset,
  prog_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state;
  logic [3:0][PC_W-1:0] progTbl;
  logic                 cfgHit;
  logic [1:0]           nextIdx;
  logic [1:0]           selIdx;
  logic [PC_W-1:0]      selAddr;

  // Table read bypasses a same-cycle write so a LOAD-time rewrite of the
  // active slot reaches PcLoadAddr on the very next edge.
  always_comb begin
    nextIdx = (bus.ProgIdx == 2'(NUM_PROGS - 1)) ? 2'd0 : bus.ProgIdx + 2'd1;
    selIdx  = (state == DONE) ? nextIdx : bus.ProgIdx;
    cfgHit  = bus.CfgWe && (32'(bus.CfgIdx) < NUM_PROGS);
    selAddr = (cfgHit && bus.CfgIdx == selIdx) ? bus.CfgAddr : progTbl[selIdx];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state          <= IDLE;
      progTbl        <= '0;
      bus.PcLoad     <= 1'b0;
      bus.PcLoadAddr <= '0;
      bus.CoreEn     <= 1'b0;
      bus.Ack        <= 1'b0;
      bus.ProgIdx    <= 2'd0;
      bus.CycleCt    <= 16'd0;
      bus.Timeout    <= 1'b0;
    end else begin
      if (cfgHit) progTbl[bus.CfgIdx] <= bus.CfgAddr;
      case (state)
        IDLE: if (bus.Start) begin
          state          <= LOAD;
          bus.PcLoad     <= 1'b1;
          bus.PcLoadAddr <= selAddr;
          bus.CycleCt    <= 16'd0;
          bus.Timeout    <= 1'b0;
        end
        LOAD: begin
          bus.PcLoadAddr <= selAddr;
          if (!bus.Start) begin
            state      <= RUN;
            bus.PcLoad <= 1'b0;
            bus.CoreEn <= 1'b1;
          end
        end
        RUN: begin
          if (bus.CycleCt != 16'hFFFF) bus.CycleCt <= bus.CycleCt + 16'd1;
          // Halt has priority over the watchdog when both hit together.
          if (bus.Instruction == HALT_OP || bus.CycleCt == TIMEOUT - 16'd1) begin
            state       <= DONE;
            bus.CoreEn  <= 1'b0;
            bus.Ack     <= 1'b1;
            bus.Timeout <= (bus.Instruction != HALT_OP);
          end
        end
        DONE: if (bus.Start) begin
          state          <= LOAD;
          bus.Ack        <= 1'b0;
          bus.CycleCt    <= 16'd0;
          bus.Timeout    <= 1'b0;
          bus.ProgIdx    <= nextIdx;
          bus.PcLoad     <= 1'b1;
          bus.PcLoadAddr <= selAddr;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer against a run-level reference model
// (entry table, program index and expected run length/timeout per program).
module tb_prog_sequencer;
  localparam int          PC_W   = 10;
  localparam int          INST_W = 9;
  localparam int          NP     = 3;
  localparam int          TO     = 8;
  localparam logic [8:0]  HALT   = 9'h1FF;

  logic Clk = 1'b0;
  logic Reset = 1'b0;

  prog_sequencer_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  prog_sequencer #(
    .NUM_PROGS(NP), .PC_W(PC_W), .INST_W(INST_W),
    .HALT_OP(HALT), .TIMEOUT(16'(TO))
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [PC_W-1:0] mTbl [NP];
  int              mIdx;
  bit              mDone;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) mTbl[i] = '0;
    mIdx  = 0;
    mDone = 0;
  endtask

  task automatic write_cfg(input int idx, input logic [PC_W-1:0] addr);
    bus.CfgWe   = 1'b1;
    bus.CfgIdx  = 2'(idx);
    bus.CfgAddr = addr;
    @(negedge Clk);
    bus.CfgWe = 1'b0;
    if (idx < NP) mTbl[idx] = addr;
  endtask

  // One complete program: Start held startLen cycles, halt on RUN edge n
  // (n > TO means the watchdog fires first).
  task automatic do_run(input int startLen, input int n, input bit pulse,
                        input bit liveWrite, input string tag);
    int              endAt;
    bit              expTo;
    logic [PC_W-1:0] nw;
    if (mDone) mIdx = (mIdx + 1) % NP;
    expTo = (n > TO);
    endAt = expTo ? TO : n;
    bus.Start = 1'b1;
    for (int c = 0; c < startLen; c++) begin
      if (liveWrite && c == 1) begin
        nw          = PC_W'($urandom);
        bus.CfgWe   = 1'b1;
        bus.CfgIdx  = 2'(mIdx);
        bus.CfgAddr = nw;
        mTbl[mIdx]  = nw;
      end
      @(negedge Clk);
      bus.CfgWe = 1'b0;
      checks++;
      if (bus.PcLoad !== 1'b1 || bus.PcLoadAddr !== mTbl[mIdx] || bus.CoreEn !== 1'b0 ||
          bus.ProgIdx !== 2'(mIdx)) begin
        errors++;
        $display("FAIL %s load c=%0d: PcLoad=%b addr=%h CoreEn=%b idx=%0d, want 1 %h 0 %0d",
                 tag, c, bus.PcLoad, bus.PcLoadAddr, bus.CoreEn, bus.ProgIdx, mTbl[mIdx], mIdx);
      end
      if (c == 0) begin
        checks++;
        if (bus.Ack !== 1'b0 || bus.CycleCt !== 16'd0 || bus.Timeout !== 1'b0) begin
          errors++;
          $display("FAIL %s loadclr: Ack=%b CycleCt=%0d Timeout=%b, want 0 0 0",
                   tag, bus.Ack, bus.CycleCt, bus.Timeout);
        end
      end
    end
    bus.Start = 1'b0;
    @(negedge Clk);
    checks++;
    if (bus.CoreEn !== 1'b1 || bus.PcLoad !== 1'b0) begin
      errors++;
      $display("FAIL %s run_entry: CoreEn=%b PcLoad=%b, want 1 0", tag, bus.CoreEn, bus.PcLoad);
    end
    for (int j = 1; j <= endAt; j++) begin
      bus.Instruction = (j == n) ? HALT : 9'($urandom_range(0, 510));
      bus.Start       = pulse && (j == 1) && (n >= 2);
      @(negedge Clk);
      checks++;
      if (bus.CycleCt !== 16'(j) || bus.CoreEn !== (j < endAt) || bus.Ack !== (j == endAt)) begin
        errors++;
        $display("FAIL %s run j=%0d: CycleCt=%0d CoreEn=%b Ack=%b, want %0d %b %b",
                 tag, j, bus.CycleCt, bus.CoreEn, bus.Ack, j, j < endAt, j == endAt);
      end
    end
    bus.Start       = 1'b0;
    bus.Instruction = '0;
    checks++;
    if (bus.Timeout !== expTo || bus.ProgIdx !== 2'(mIdx)) begin
      errors++;
      $display("FAIL %s done: Timeout=%b idx=%0d, want %b %0d",
               tag, bus.Timeout, bus.ProgIdx, expTo, mIdx);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if (bus.Ack !== 1'b1 || bus.CycleCt !== 16'(endAt) || bus.CoreEn !== 1'b0 ||
        bus.Timeout !== expTo) begin
      errors++;
      $display("FAIL %s frozen: Ack=%b CycleCt=%0d CoreEn=%b Timeout=%b, want 1 %0d 0 %b",
               tag, bus.Ack, bus.CycleCt, bus.CoreEn, bus.Timeout, endAt, expTo);
    end
    mDone = 1;
  endtask

  task automatic test_reset();
    bus.Start = 1'b0; bus.Instruction = '0; bus.CfgWe = 1'b0; bus.CfgIdx = '0; bus.CfgAddr = '0;
    Reset = 1'b0;
    model_reset();
    #12;
    checks++;
    if (bus.PcLoad !== 1'b0 || bus.PcLoadAddr !== '0 || bus.CoreEn !== 1'b0 || bus.Ack !== 1'b0 ||
        bus.ProgIdx !== 2'd0 || bus.CycleCt !== 16'd0 || bus.Timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: PcLoad=%b addr=%h CoreEn=%b Ack=%b idx=%0d CycleCt=%0d Timeout=%b, want all 0",
               bus.PcLoad, bus.PcLoadAddr, bus.CoreEn, bus.Ack, bus.ProgIdx, bus.CycleCt, bus.Timeout);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_halt_basic();
    write_cfg(0, 10'h020);
    do_run(3, 6, 1'b0, 1'b0, "halt_basic");
  endtask

  task automatic test_reset_mid_run();
    bus.Start = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    @(negedge Clk);
    for (int j = 0; j < 3; j++) begin
      bus.Instruction = 9'($urandom_range(0, 510));
      @(negedge Clk);
    end
    checks++;
    if (bus.CoreEn !== 1'b1 || bus.CycleCt !== 16'd3 || bus.ProgIdx !== 2'd1) begin
      errors++;
      $display("FAIL midrun_pre: CoreEn=%b CycleCt=%0d idx=%0d, want 1 3 1",
               bus.CoreEn, bus.CycleCt, bus.ProgIdx);
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (bus.CoreEn !== 1'b0 || bus.Ack !== 1'b0 || bus.CycleCt !== 16'd0 || bus.ProgIdx !== 2'd0 ||
        bus.PcLoad !== 1'b0 || bus.PcLoadAddr !== '0 || bus.Timeout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: CoreEn=%b Ack=%b CycleCt=%0d idx=%0d PcLoad=%b addr=%h, want all 0",
               bus.CoreEn, bus.Ack, bus.CycleCt, bus.ProgIdx, bus.PcLoad, bus.PcLoadAddr);
    end
    model_reset();
    bus.Instruction = '0;
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  // Slot 0 left at its reset value; out-of-range write must not land anywhere.
  task automatic test_three_programs();
    write_cfg(1, 10'h100);
    write_cfg(2, 10'h200);
    write_cfg(3, 10'h3FF);
    for (int r = 0; r < 4; r++)
      do_run($urandom_range(1, 3), $urandom_range(1, TO - 1), 1'b0, 1'b0, "three_progs");
  endtask

  task automatic test_timeout();
    do_run(1, TO + 1 + $urandom_range(0, 5), 1'b0, 1'b0, "timeout");
    do_run(2, TO, 1'b0, 1'b0, "halt_at_limit");
  endtask

  task automatic test_start_in_run_and_live_write();
    do_run(3, 5, 1'b1, 1'b1, "live_write");
    for (int r = 0; r < 4; r++) begin
      write_cfg($urandom_range(0, 3), PC_W'($urandom));
      do_run($urandom_range(2, 4), $urandom_range(1, TO + 3), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_halt_basic();
    test_reset_mid_run();
    test_three_programs();
    test_timeout();
    test_start_in_run_and_live_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller for the CSE 141L processor core. It owns the Start/Ack handshake with the test bench and keeps a small table of program entry addresses. It loads the program counter with the selected entry, gates core execution until a halt opcode or a watchdog timeout, and counts executed cycles. It sits beside the program counter and instruction ROM in the top level, driving their load and enable controls.

## Interface
Parameters:
- NUM_PROGS, 3, number of entry-address table slots (2..4)
- PC_W, 10, program counter width
- INST_W, 9, instruction width
- HALT_OP, 9'h1FF, instruction encoding that ends a program
- TIMEOUT, 16'd4000, maximum RUN cycles before forced stop (1..16'hFFFF)

Ports:
- Clk  in  1  clock, posedge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  bench request; level, sampled on posedge
- Instruction  in  INST_W  current instruction from instruction ROM
- CfgWe  in  1  entry-table write enable
- CfgIdx  in  2  entry-table slot to write
- CfgAddr  in  PC_W  entry address to write
- PcLoad  out  1  program counter load strobe, level while in LOAD
- PcLoadAddr  out  PC_W  address to load into the program counter
- CoreEn  out  1  enables PC advance and register/memory writes
- Ack  out  1  program finished
- ProgIdx  out  2  slot index of the current or last program
- CycleCt  out  16  RUN cycles of the current or last program
- Timeout  out  1  last program was stopped by the watchdog

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- Reset values: state IDLE, PcLoad 0, PcLoadAddr 0, CoreEn 0, Ack 0, ProgIdx 0, CycleCt 0, Timeout 0, all table entries 0.
- **IDLE**, Start=1:
  - go to LOAD with ProgIdx kept at 0.
  - clear CycleCt and Timeout.
- **LOAD**:
  - PcLoad=1 and PcLoadAddr=table[ProgIdx] on every cycle.
  - Start=0 moves to RUN: PcLoad=0, CoreEn=1.
  - Start held high keeps LOAD indefinitely.
- **RUN**:
  - CycleCt increments every cycle and saturates at 16'hFFFF.
  - Instruction==HALT_OP goes to DONE: CoreEn=0, Ack=1, Timeout=0. The halt cycle is counted.
  - Otherwise, if CycleCt==TIMEOUT-1, go to DONE with Timeout=1.
  - Halt and timeout in the same cycle: halt wins, Timeout=0.
  - Start is ignored in RUN.
- **DONE**:
  - Ack=1 is held. CycleCt, ProgIdx and Timeout are frozen.
  - Start=1 goes to LOAD: Ack=0, CycleCt=0, Timeout=0.
  - On that transition ProgIdx increments, wrapping NUM_PROGS-1 to 0.
- Entry-table writes:
  - accepted in any state; the slot updates on the clock edge.
  - a write to the active slot while in LOAD shows on PcLoadAddr the next cycle.
  - writes with CfgIdx>=NUM_PROGS are ignored.
- Reset asserted mid-RUN: all outputs return to their reset values immediately (asynchronously) and the table clears. CoreEn dropping stops the core.

## Timing
- Start sampled high at edge k in IDLE or DONE gives PcLoad=1 after edge k.
- Start sampled low at edge m in LOAD gives CoreEn=1 after m. The first ROM fetch at the loaded PC occurs in cycle m+1.
- HALT_OP present at edge h gives CoreEn=0 and Ack=1 after h. This is a latency of 1 cycle.
- CycleCt after halt equals the number of edges in RUN, including h.
- Ack deasserts the cycle after Start is sampled high in DONE.
- Reset deassertion is synchronized by the user. The block acts on the first posedge with Reset=1.

## Test plan
- Reset, write table[0]=10'h020. Start high 3 cycles, then low. Expect PcLoad=1 for 3 cycles with PcLoadAddr=10'h020, then CoreEn=1.
- Drive 5 non-halt instructions, then HALT_OP. Expect Ack=1 and CoreEn=0 one cycle later, CycleCt=6, Timeout=0.
- Run three successive programs with table={10'h000,10'h100,10'h200}. Expect ProgIdx 0,1,2 with matching PcLoadAddr, and a 4th run back at ProgIdx=0 with address 10'h000.
- TIMEOUT=8 and no halt. Expect DONE after 8 RUN cycles with CycleCt=8, Timeout=1. Also place HALT_OP on cycle 8: expect Timeout=0.
- Pull Reset low mid-RUN. Expect CoreEn=0, Ack=0, CycleCt=0, ProgIdx=0 immediately. Write CfgIdx=3 with NUM_PROGS=3: expect no table change.
- Pulse Start during RUN. Expect no effect. Write table[ProgIdx] while in LOAD: expect PcLoadAddr updated the next cycle.
